// File: rtl/stb_meas_pkg.sv
// Shared types for the stb_gen measurement sequencer.
package stb_meas_pkg;

  typedef enum logic [3:0] {
    IDLE, RST_GEN, ARM, WAIT_RDY, ACC, EVAL, RETRY, RUN, FAIL
  } stb_meas_state_e;

  typedef enum logic [1:0] {
    FC_NONE, FC_ERR, FC_TIMEOUT, FC_SPREAD
  } fail_code_e;

endpackage

// File: rtl/stb_meas_acc.sv
// Period accumulator: running sum, min and max of one detection set,
// with shifted average and max-min spread.
module stb_meas_acc #(
  parameter int W    = 32,
  parameter int MAXL = 4,
  parameter int LW   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          add,
  input  logic [W-1:0]  din,
  input  logic [LW-1:0] shift,
  output logic [W-1:0]  avg,
  output logic [W-1:0]  spread
);

  localparam int SW = W + MAXL;

  logic [SW-1:0] sum;
  logic [W-1:0]  min_v;
  logic [W-1:0]  max_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      min_v <= '1;
      max_v <= '0;
    end else if (clr) begin
      sum   <= '0;
      min_v <= '1;
      max_v <= '0;
    end else if (add) begin
      sum <= sum + SW'(din);
      if (din < min_v) min_v <= din;
      if (din > max_v) max_v <= din;
    end
  end

  // Shift never exceeds MAXL, so the quotient always fits in W bits.
  assign avg    = W'(sum >> shift);
  assign spread = max_v - min_v;

endmodule

// File: rtl/stb_meas_ctrl.sv
// Sequencer for one stb_gen: reset, N detections, average with spread check,
// retry on error/timeout/spread, then enable the strobe output.
module stb_meas_ctrl
  import stb_meas_pkg::*;
#(
  parameter int T_CNT_WIDTH  = 32,
  parameter int MAX_AVG_LOG2 = 4,
  parameter int MAX_RETRY    = 3,
  parameter int TIMEOUT_W    = 24,
  parameter int RST_CYCLES   = 2
) (
  input  logic                              clk_i,
  input  logic                              arst_ni,
  input  logic                              start_i,
  input  logic                              abort_i,
  input  logic [$clog2(MAX_AVG_LOG2+1)-1:0] avg_log2_i,
  input  logic [T_CNT_WIDTH-1:0]            tol_i,
  input  logic [TIMEOUT_W-1:0]              timeout_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              fail_o,
  output logic [1:0]                        fail_code_o,
  output logic [T_CNT_WIDTH-1:0]            period_o,
  output logic [T_CNT_WIDTH-1:0]            spread_o,
  output logic [1:0]                        retry_cnt_o,
  output logic                              stbgen_arst_o,
  output logic                              stbgen_run_det_o,
  output logic                              stbgen_oe_o,
  input  logic                              stbgen_rdy_i,
  input  logic                              stbgen_err_i,
  input  logic [T_CNT_WIDTH-1:0]            stbgen_period_i
);

  localparam int AW = $clog2(MAX_AVG_LOG2 + 1);
  localparam int NW = MAX_AVG_LOG2 + 1;
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  stb_meas_state_e        state, nxt;
  fail_code_e             code_nxt;
  logic                   load_code;
  logic                   accept;
  logic [AW-1:0]          avg_q;
  logic [T_CNT_WIDTH-1:0] tol_q;
  logic [TIMEOUT_W-1:0]   timeout_q;
  logic [TIMEOUT_W-1:0]   wd;
  logic                   seen_low;
  logic [NW-1:0]          n;
  logic [NW-1:0]          n_tgt;
  logic [RW-1:0]          rst_cnt;
  logic [T_CNT_WIDTH-1:0] avg;
  logic [T_CNT_WIDTH-1:0] spread;

  assign n_tgt = (NW'(1) << avg_q) - NW'(1);

  stb_meas_acc #(
    .W   (T_CNT_WIDTH),
    .MAXL(MAX_AVG_LOG2),
    .LW  (AW)
  ) u_acc (
    .clk   (clk_i),
    .rst_n (arst_ni),
    .clr   (state == RST_GEN),
    .add   (state == ACC),
    .din   (stbgen_period_i),
    .shift (avg_q),
    .avg   (avg),
    .spread(spread)
  );

  always_comb begin
    nxt       = state;
    code_nxt  = FC_NONE;
    load_code = 1'b0;
    accept    = 1'b0;
    if (abort_i) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          accept = 1'b1; load_code = 1'b1; nxt = RST_GEN;
        end
        RST_GEN: if (rst_cnt == RW'(RST_CYCLES - 1)) nxt = ARM;
        ARM: nxt = WAIT_RDY;
        WAIT_RDY: begin
          // Ready is only trusted after a low phase: a stale high from the
          // previous detection must not be taken as a new result.
          if (stbgen_err_i) begin
            nxt = RETRY; code_nxt = FC_ERR; load_code = 1'b1;
          end else if (timeout_q != '0 && wd == timeout_q) begin
            nxt = RETRY; code_nxt = FC_TIMEOUT; load_code = 1'b1;
          end else if (stbgen_rdy_i && seen_low) begin
            nxt = ACC;
          end
        end
        ACC: nxt = (n == n_tgt) ? EVAL : ARM;
        EVAL: if (spread > tol_q) begin
          nxt = RETRY; code_nxt = FC_SPREAD; load_code = 1'b1;
        end else begin
          nxt = RUN;
        end
        RETRY: nxt = (retry_cnt_o == 2'(MAX_RETRY)) ? FAIL : RST_GEN;
        RUN: if (stbgen_err_i) begin
          nxt = FAIL; code_nxt = FC_ERR; load_code = 1'b1;
        end else if (start_i) begin
          accept = 1'b1; load_code = 1'b1; nxt = RST_GEN;
        end
        FAIL: if (start_i) begin
          accept = 1'b1; load_code = 1'b1; nxt = RST_GEN;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state            <= IDLE;
      avg_q            <= '0;
      tol_q            <= '0;
      timeout_q        <= '0;
      wd               <= '0;
      seen_low         <= 1'b0;
      n                <= '0;
      rst_cnt          <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      fail_o           <= 1'b0;
      fail_code_o      <= '0;
      period_o         <= '0;
      spread_o         <= '0;
      retry_cnt_o      <= '0;
      stbgen_arst_o    <= 1'b0;
      stbgen_run_det_o <= 1'b0;
      stbgen_oe_o      <= 1'b0;
    end else begin
      state <= nxt;
      if (load_code) fail_code_o <= code_nxt;
      if (accept) begin
        avg_q       <= (avg_log2_i > AW'(MAX_AVG_LOG2)) ? AW'(MAX_AVG_LOG2) : avg_log2_i;
        tol_q       <= tol_i;
        timeout_q   <= timeout_i;
        retry_cnt_o <= '0;
      end else if (state == RETRY && nxt == RST_GEN) begin
        retry_cnt_o <= retry_cnt_o + 2'd1;
      end
      rst_cnt <= (state == RST_GEN) ? rst_cnt + RW'(1) : '0;
      if (state == ARM) begin
        seen_low <= 1'b0;
        wd       <= '0;
      end else if (state == WAIT_RDY) begin
        if (!stbgen_rdy_i) seen_low <= 1'b1;
        if (wd != '1) wd <= wd + TIMEOUT_W'(1);
      end
      if (state == RST_GEN) n <= '0;
      else if (state == ACC) n <= n + NW'(1);
      if (state == EVAL) begin
        spread_o <= spread;
        if (nxt == RUN) period_o <= avg;
      end
      // Outputs are registered from the next state so they align with it.
      busy_o           <= !(nxt inside {IDLE, RUN, FAIL});
      done_o           <= (state == EVAL) && (nxt == RUN);
      fail_o           <= (nxt == FAIL);
      stbgen_arst_o    <= (nxt == RST_GEN);
      stbgen_run_det_o <= (nxt == ARM);
      stbgen_oe_o      <= (nxt == RUN);
    end
  end

endmodule

// File: tb/tb_stb_meas_ctrl.sv
// Scoreboard bench for stb_meas_ctrl with a behavioural stb_gen model.
module tb_stb_meas_ctrl;

  typedef enum int {M_NORMAL, M_NEVER, M_ERR2, M_STALE} mode_e;

  typedef struct {
    bit          is_fail;
    logic [31:0] period;
    logic [31:0] spread;
    logic [1:0]  code;
    logic [1:0]  retry;
    int          rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        arst_ni = 1'b1;
  logic        start_i, abort_i;
  logic [2:0]  avg_log2_i;
  logic [31:0] tol_i;
  logic [23:0] timeout_i;
  logic        busy_o, done_o, fail_o;
  logic [1:0]  fail_code_o, retry_cnt_o;
  logic [31:0] period_o, spread_o;
  logic        stbgen_arst_o, stbgen_run_det_o, stbgen_oe_o;
  logic        stbgen_rdy_i, stbgen_err_i;
  logic [31:0] stbgen_period_i;

  int          n_tests, n_fail;
  exp_t        sb[$];
  logic [31:0] pq[$];
  mode_e       mode;
  int          rd_cnt, cyc, rd_last, rd_gap, arst_run, arst_last;
  int          kick_req, kick_done;

  stb_meas_ctrl #(
    .T_CNT_WIDTH (32),
    .MAX_AVG_LOG2(4),
    .MAX_RETRY   (3),
    .TIMEOUT_W   (24),
    .RST_CYCLES  (2)
  ) dut (
    .clk_i           (clk),
    .arst_ni         (arst_ni),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .avg_log2_i      (avg_log2_i),
    .tol_i           (tol_i),
    .timeout_i       (timeout_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .fail_o          (fail_o),
    .fail_code_o     (fail_code_o),
    .period_o        (period_o),
    .spread_o        (spread_o),
    .retry_cnt_o     (retry_cnt_o),
    .stbgen_arst_o   (stbgen_arst_o),
    .stbgen_run_det_o(stbgen_run_det_o),
    .stbgen_oe_o     (stbgen_oe_o),
    .stbgen_rdy_i    (stbgen_rdy_i),
    .stbgen_err_i    (stbgen_err_i),
    .stbgen_period_i (stbgen_period_i)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void push(input bit f, input logic [31:0] p, input logic [31:0] s,
                               input logic [1:0] c, input logic [1:0] r, input int rd);
    exp_t e;
    e.is_fail = f; e.period = p; e.spread = s; e.code = c; e.retry = r; e.rd = rd;
    sb.push_back(e);
  endfunction

  // stb_gen model: drops rdy on run_det, reports a period 6 cycles later.
  task automatic model();
    int det = 0;
    int mcyc = 0;
    bit active = 1'b0;
    forever begin
      @(negedge clk);
      if (stbgen_arst_o) begin
        stbgen_err_i = 1'b0; stbgen_rdy_i = 1'b1; det = 0; active = 1'b0;
      end else if (stbgen_run_det_o) begin
        det++; mcyc = 0; active = 1'b1;
        stbgen_rdy_i = (mode == M_STALE);
        if (mode == M_STALE) stbgen_period_i = 32'd999;
        if (mode == M_ERR2 && det == 2) stbgen_err_i = 1'b1;
      end else if (active) begin
        mcyc++;
        if (mode == M_STALE && mcyc == 3) stbgen_rdy_i = 1'b0;
        if (mode != M_NEVER && mcyc == 6) begin
          stbgen_period_i = (pq.size() > 0) ? pq.pop_front() : 32'd100;
          stbgen_rdy_i = 1'b1;
          active = 1'b0;
        end
      end
      if (kick_req != kick_done) begin
        stbgen_err_i = 1'b1;
        kick_done = kick_req;
      end
    end
  endtask

  task automatic monitor();
    bit   fail_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (stbgen_run_det_o) begin
        rd_cnt++; rd_gap = cyc - rd_last; rd_last = cyc;
      end
      if (stbgen_arst_o) arst_run++;
      else if (arst_run != 0) begin
        arst_last = arst_run; arst_run = 0;
      end
      if (done_o || (fail_o && !fail_prev)) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_event: done=%0b fail=%0b, expected no event", done_o, fail_o);
        end else begin
          e = sb.pop_front();
          chk("ev_done",    64'(done_o),      64'(!e.is_fail));
          chk("ev_fail",    64'(fail_o),      64'(e.is_fail));
          chk("ev_period",  64'(period_o),    64'(e.period));
          chk("ev_spread",  64'(spread_o),    64'(e.spread));
          chk("ev_code",    64'(fail_code_o), 64'(e.code));
          chk("ev_retry",   64'(retry_cnt_o), 64'(e.retry));
          chk("ev_run_det", 64'(rd_cnt),      64'(e.rd));
          chk("ev_oe",      64'(stbgen_oe_o), 64'(!e.is_fail));
        end
      end
      fail_prev = fail_o;
    end
  endtask

  task automatic do_start(input logic [2:0] al, input logic [31:0] tol, input logic [23:0] to);
    @(negedge clk);
    avg_log2_i = al; tol_i = tol; timeout_i = to; start_i = 1'b1; rd_cnt = 0;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_sb(input string name, input int lim);
    for (int i = 0; i < lim && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: %0d expected events still pending after %0d cycles, required 0", name, sb.size(), lim);
      sb.delete();
    end
  endtask

  task automatic wait_rd(input string name);
    for (int i = 0; i < 40 && rd_cnt == 0; i++) @(negedge clk);
    chk(name, 64'(rd_cnt != 0), 64'(1));
  endtask

  task automatic stimulus();
    #2 arst_ni = 1'b0;
    #2;
    chk("rst_busy",    64'(busy_o),           64'(0));
    chk("rst_done",    64'(done_o),           64'(0));
    chk("rst_fail",    64'(fail_o),           64'(0));
    chk("rst_code",    64'(fail_code_o),      64'(0));
    chk("rst_period",  64'(period_o),         64'(0));
    chk("rst_spread",  64'(spread_o),         64'(0));
    chk("rst_retry",   64'(retry_cnt_o),      64'(0));
    chk("rst_arst",    64'(stbgen_arst_o),    64'(0));
    chk("rst_run_det", 64'(stbgen_run_det_o), 64'(0));
    chk("rst_oe",      64'(stbgen_oe_o),      64'(0));
    repeat (2) @(negedge clk);
    arst_ni = 1'b1;

    // Four samples, spread 4 within tol 8; a start while busy is ignored.
    mode = M_NORMAL;
    pq = '{32'd100, 32'd102, 32'd98, 32'd100};
    push(1'b0, 32'd100, 32'd4, 2'd0, 2'd0, 4);
    do_start(3'd2, 32'd8, 24'd1000);
    repeat (10) @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_sb("avg4_run", 400);

    // Spread 30 fails once, retry with all-100 passes.
    pq = '{32'd100, 32'd130, 32'd100, 32'd100, 32'd100, 32'd100, 32'd100, 32'd100};
    push(1'b0, 32'd100, 32'd0, 2'd3, 2'd1, 8);
    do_start(3'd2, 32'd8, 24'd1000);
    wait_sb("spread_retry", 600);
    chk("retry_arst_len", 64'(arst_last), 64'(2));

    // No rdy ever: 4 timed-out attempts, ARM-to-ARM spacing 1+51+1+2.
    mode = M_NEVER;
    pq.delete();
    push(1'b1, 32'd100, 32'd0, 2'd2, 2'd3, 4);
    do_start(3'd2, 32'd8, 24'd50);
    wait_sb("timeout_fail", 400);
    chk("timeout_gap", 64'(rd_gap), 64'(55));

    // err on the second detection of every attempt.
    mode = M_ERR2;
    push(1'b1, 32'd100, 32'd0, 2'd1, 2'd3, 8);
    do_start(3'd2, 32'd8, 24'd1000);
    chk("start_clr_fail", 64'(fail_o),      64'(0));
    chk("start_clr_code", 64'(fail_code_o), 64'(0));
    wait_sb("err_fail", 800);

    // Single sample with tol 0, then err while running.
    mode = M_NORMAL;
    pq = '{32'd200};
    push(1'b0, 32'd200, 32'd0, 2'd0, 2'd0, 1);
    do_start(3'd0, 32'd0, 24'd1000);
    wait_sb("single_run", 200);
    push(1'b1, 32'd200, 32'd0, 2'd1, 2'd0, 1);
    @(negedge clk);
    kick_req++;
    wait_sb("run_err", 20);

    // Stale rdy high after run_det must not capture the bogus 999.
    mode = M_STALE;
    pq = '{32'd250};
    push(1'b0, 32'd250, 32'd0, 2'd0, 2'd0, 1);
    do_start(3'd0, 32'd0, 24'd1000);
    wait_sb("stale_rdy", 200);

    // avg_log2 7 clamps to 4: sixteen all-ones periods average exactly.
    mode = M_NORMAL;
    pq.delete();
    for (int i = 0; i < 16; i++) pq.push_back(32'hFFFF_FFFF);
    push(1'b0, 32'hFFFF_FFFF, 32'd0, 2'd0, 2'd0, 16);
    do_start(3'd7, 32'd0, 24'd1000);
    wait_sb("max_sum", 600);

    // Abort during WAIT_RDY keeps period_o; abort beats start in IDLE.
    pq = '{32'd300};
    do_start(3'd0, 32'd0, 24'd1000);
    wait_rd("abort_rd_seen");
    repeat (2) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_busy",   64'(busy_o),      64'(0));
    chk("abort_oe",     64'(stbgen_oe_o), 64'(0));
    chk("abort_period", 64'(period_o),    64'(32'hFFFF_FFFF));
    chk("abort_done",   64'(done_o),      64'(0));
    start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    chk("abort_start_busy", 64'(busy_o),        64'(0));
    chk("abort_start_arst", 64'(stbgen_arst_o), 64'(0));
    repeat (10) @(negedge clk);

    // Reset asserted while in ACC.
    pq = '{32'd400};
    do_start(3'd0, 32'd0, 24'd1000);
    wait_rd("acc_rd_seen");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (stbgen_rdy_i) break;
    end
    chk("acc_rdy_seen", 64'(stbgen_rdy_i), 64'(1));
    arst_ni = 1'b0;
    #1;
    chk("acc_rst_busy",   64'(busy_o),        64'(0));
    chk("acc_rst_oe",     64'(stbgen_oe_o),   64'(0));
    chk("acc_rst_period", 64'(period_o),      64'(0));
    chk("acc_rst_done",   64'(done_o),        64'(0));
    chk("acc_rst_code",   64'(fail_code_o),   64'(0));
    chk("acc_rst_arst",   64'(stbgen_arst_o), 64'(0));
    @(negedge clk);
    arst_ni = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    start_i = 1'b0; abort_i = 1'b0; avg_log2_i = '0; tol_i = '0; timeout_i = '0;
    stbgen_rdy_i = 1'b1; stbgen_err_i = 1'b0; stbgen_period_i = '0;
    n_tests = 0; n_fail = 0; mode = M_NORMAL;
    rd_cnt = 0; cyc = 0; rd_last = 0; rd_gap = 0; arst_run = 0; arst_last = 0;
    kick_req = 0; kick_done = 0;
    fork
      model();
      monitor();
      stimulus();
    join_any
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
